// File: rtl/fetch_unit.sv
// Fetch unit: requests one instruction word at pc, holds it for decode, then steps pc (sequential/branch/jump).
// Latency: 1 cycle IDLE after reset; fetch completes in the cycle imem_ready is seen; 2 cycles per instruction at best.
// Backpressure: waits in FETCH for imem_ready, holds VALID until instr_ack. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] pcplus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        w_load_instr;
    logic        w_load_pc;
    logic        w_taken;
    logic [31:0] w_pcplus4;
    logic [31:0] w_br_off;
    logic [31:0] w_pc_nxt;

    assign w_pcplus4 = r_pc + 32'd4;
    assign w_taken   = branch[1] & (zero ^ branch[0]);
    assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Jump outranks a taken branch when the decoder raises both.
    always_comb begin
        w_pc_nxt = w_pcplus4;
        if (jump) begin
            w_pc_nxt = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_taken) begin
            w_pc_nxt = w_pcplus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        w_load_pc    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = VALID;
                end
            end
            VALID: begin
                if (instr_ack) begin
                    w_load_pc   = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_load_pc) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_load_pc) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (r_state == FETCH && !imem_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    // Outputs decode straight from state so reset drops them without waiting for an edge.
    assign imem_req    = (r_state == FETCH);
    assign instr_valid = (r_state == VALID);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pcplus4     = w_pcplus4;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];

endmodule
